// File: rtl/dmem_latency_ctrl_if.sv
// Memory-stage request/response bundle between the pipeline and the latency-controlled data memory.
interface dmem_latency_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             MemReadM;
    logic             MemWriteM;
    logic [2:0]       Funct3M;
    logic [31:0]      DataAdrM;
    logic [31:0]      WriteDataM;
    logic [31:0]      ReadDataM;
    logic             StallMem;
    logic             MisalignM;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output MemReadM, MemWriteM, Funct3M, DataAdrM, WriteDataM,
        input  ReadDataM, StallMem, MisalignM, StallCount
    );

    modport slave (
        input  MemReadM, MemWriteM, Funct3M, DataAdrM, WriteDataM,
        output ReadDataM, StallMem, MisalignM, StallCount
    );
endinterface

// File: rtl/dmem_latency_ctrl.sv
// RV32I data memory with configurable access latency, byte/half extension,
// misalignment detection, stall handshake and a saturating stall-cycle counter.
module dmem_latency_ctrl #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned CNT_W       = 32
) (
    input logic               clk,
    input logic               reset,
    dmem_latency_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            rd, wr, req, legal, aligned, valid, stall, complete;
    logic [2:0]      f3;
    logic [31:0]     adr, wd, word, rdata;
    logic [AW-1:0]   idx;
    logic [7:0]      bsel;
    logic [15:0]     hsel;
    logic [3:0]      be;
    logic [31:0]     wlane;
    logic            unused_addr;

    assign rd  = bus.MemReadM;
    assign wr  = bus.MemWriteM;
    assign f3  = bus.Funct3M;
    assign adr = bus.DataAdrM;
    assign wd  = bus.WriteDataM;
    assign req = rd | wr;
    assign idx = adr[AW+1:2];
    assign unused_addr = ^adr[31:AW+2];

    // A store wins when both strobes are set, so store legality applies.
    assign legal   = wr ? (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)
                        : (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                           f3 == 3'b100 || f3 == 3'b101);
    assign aligned = !((f3[1:0] == 2'b01 && adr[0]) ||
                       (f3[1:0] == 2'b10 && adr[1:0] != 2'b00));
    assign valid   = req && legal && aligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    if (LATENCY == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt_q == CW'(LATENCY)) state_d = DONE;
                else                       cnt_d   = cnt_q + CW'(1);
            end
            DONE: begin
                complete = valid;
                state_d  = IDLE;
                cnt_d    = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturating count of cycles spent stalling the pipeline.
    always_ff @(posedge clk) begin
        if (reset)                        stall_cnt_q <= '0;
        else if (stall && ~&stall_cnt_q)  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    always_comb begin
        be    = 4'b1111;
        wlane = wd;
        case (f3[1:0])
            2'b00: begin
                be    = 4'b0001 << adr[1:0];
                wlane = {4{wd[7:0]}};
            end
            2'b01: begin
                be    = adr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wd[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wd;
            end
        endcase
    end

    // Array is deliberately not reset; a store cut off by reset never commits.
    always_ff @(posedge clk) begin
        if (!reset && complete && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    assign word = mem[idx];
    assign bsel = 8'(word >> {adr[1:0], 3'b000});
    assign hsel = adr[1] ? word[31:16] : word[15:0];

    always_comb begin
        rdata = '0;
        if (complete && rd && !wr) begin
            case (f3)
                3'b000:  rdata = {{24{bsel[7]}}, bsel};
                3'b001:  rdata = {{16{hsel[15]}}, hsel};
                3'b010:  rdata = word;
                3'b100:  rdata = {24'd0, bsel};
                3'b101:  rdata = {16'd0, hsel};
                default: rdata = '0;
            endcase
        end
    end

    assign bus.ReadDataM  = rdata;
    assign bus.StallMem   = stall;
    assign bus.MisalignM  = req && !(legal && aligned);
    assign bus.StallCount = stall_cnt_q;
endmodule

// File: tb/tb_dmem_latency_ctrl.sv
// Randomized + directed bench for dmem_latency_ctrl (LATENCY=2 and LATENCY=0 builds)
// against a transaction-level memory model.
module tb_dmem_latency_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_latency_ctrl_if #(.CNT_W(8))  b0();
    dmem_latency_ctrl_if #(.CNT_W(32)) b1();

    dmem_latency_ctrl #(.DEPTH_WORDS(64), .LATENCY(2), .CNT_W(8))  dut0 (.clk(clk), .reset(reset), .bus(b0));
    dmem_latency_ctrl #(.DEPTH_WORDS(64), .LATENCY(0), .CNT_W(32)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    typedef struct {
        int          id;
        bit          en;
        bit          st;
        bit          mis;
        logic [31:0] rd;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          n_err = 0;
    int          n_chk = 0;
    logic [31:0] mm [2][64];
    logic [31:0] sc [2];
    logic [31:0] last_rd [2];
    bit          last_mis [2];
    bit          last_st [2];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the queued model expectations.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.en) begin
                if (e.id == 0) begin
                    chk("d0_stall", 32'(b0.StallMem), 32'(e.st));
                    chk("d0_mis", 32'(b0.MisalignM), 32'(e.mis));
                    chk("d0_rdata", b0.ReadDataM, e.rd);
                    chk("d0_cnt", 32'(b0.StallCount), e.cnt);
                    last_rd[0] = b0.ReadDataM; last_mis[0] = b0.MisalignM; last_st[0] = b0.StallMem;
                end else begin
                    chk("d1_stall", 32'(b1.StallMem), 32'(e.st));
                    chk("d1_mis", 32'(b1.MisalignM), 32'(e.mis));
                    chk("d1_rdata", b1.ReadDataM, e.rd);
                    chk("d1_cnt", b1.StallCount, e.cnt);
                    last_rd[1] = b1.ReadDataM; last_mis[1] = b1.MisalignM; last_st[1] = b1.StallMem;
                end
            end
        end
    end

    function automatic logic [31:0] smax(int id);
        return (id == 0) ? 32'd255 : 32'hFFFF_FFFF;
    endfunction

    function automatic bit is_bad(bit wr, logic [2:0] f3, logic [31:0] a);
        int  f = int'(f3);
        int  sz = f % 4;
        bit  legal = wr ? (f <= 2) : (f <= 2 || f == 4 || f == 5);
        bit  al = (sz == 1) ? (a % 2 == 0) : (sz == 2) ? (a % 4 == 0) : 1'b1;
        return !(legal && al);
    endfunction

    function automatic logic [31:0] ld_val(logic [31:0] w, logic [2:0] f3, logic [31:0] a);
        logic [31:0] b = (w >> (8 * (a % 4))) & 32'hFF;
        logic [31:0] h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd2: return w;
            3'd4: return b;
            3'd5: return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] st_val(logic [31:0] w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        logic [31:0] m;
        if (f3 == 3'd0) begin
            m = 32'hFF << (8 * (a % 4));
            return (w & ~m) | ((wd & 32'hFF) << (8 * (a % 4)));
        end else if (f3 == 3'd1) begin
            m = 32'hFFFF << (16 * ((a / 2) % 2));
            return (w & ~m) | ((wd & 32'hFFFF) << (16 * ((a / 2) % 2)));
        end
        return wd;
    endfunction

    task automatic cyc(int id, bit rst, bit rd, bit wr, logic [2:0] f3, logic [31:0] a,
                       logic [31:0] wd, bit en, bit st, bit mis, logic [31:0] rdv);
        exp_t e;
        @(posedge clk); #1;
        reset = rst;
        b0.MemReadM = (id == 0) && rd; b0.MemWriteM = (id == 0) && wr;
        b1.MemReadM = (id == 1) && rd; b1.MemWriteM = (id == 1) && wr;
        b0.Funct3M = f3; b0.DataAdrM = a; b0.WriteDataM = wd;
        b1.Funct3M = f3; b1.DataAdrM = a; b1.WriteDataM = wd;
        e.id = id; e.en = en; e.st = st; e.mis = mis; e.rd = rdv; e.cnt = sc[id];
        q.push_back(e);
        if (st && sc[id] != smax(id)) sc[id] = sc[id] + 32'd1;
    endtask

    task automatic idle(int id, int n);
        for (int k = 0; k < n; k++) cyc(id, 0, 0, 0, 3'd0, 32'd0, 32'd0, 1, 0, 0, 32'd0);
    endtask

    // One complete access: held for the full stall window, then released.
    task automatic txn(int id, bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        int          lat = (id == 0) ? 2 : 0;
        bit          req = rd | wr;
        bit          bad = is_bad(wr, f3, a);
        int          ix  = int'((a / 4) % 64);
        logic [31:0] w   = mm[id][ix];
        if (!(req && !bad)) begin
            cyc(id, 0, rd, wr, f3, a, wd, 1, 0, req, 32'd0);
        end else begin
            if (lat > 0)
                for (int k = 0; k <= lat; k++) cyc(id, 0, rd, wr, f3, a, wd, 1, 1, 0, 32'd0);
            cyc(id, 0, rd, wr, f3, a, wd, 1, 0, 0, (rd && !wr) ? ld_val(w, f3, a) : 32'd0);
            if (wr) mm[id][ix] = st_val(w, f3, a, wd);
        end
        @(negedge clk); #1;
    endtask

    task automatic rand_txn(int id);
        bit          rd = 1'($urandom_range(0, 1));
        bit          wr = 1'($urandom_range(0, 1));
        logic [2:0]  f3;
        logic [31:0] a = $urandom;
        int          pick;
        if (!rd && !wr && $urandom_range(0, 1) == 1) rd = 1'b1;
        if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
        else if (wr) f3 = 3'($urandom_range(0, 2));
        else begin
            pick = $urandom_range(0, 4);
            f3 = (pick < 3) ? 3'(pick) : 3'(pick + 1);
        end
        if ($urandom_range(0, 4) != 0) begin
            if (f3[1:0] == 2'b01) a = a & ~32'd1;
            if (f3[1:0] == 2'b10) a = a & ~32'd3;
        end
        txn(id, rd, wr, f3, a, $urandom);
    endtask

    initial begin
        reset = 1'b1;
        sc[0] = 32'd0; sc[1] = 32'd0;
        b0.MemReadM = 0; b0.MemWriteM = 0; b0.Funct3M = 0; b0.DataAdrM = 0; b0.WriteDataM = 0;
        b1.MemReadM = 0; b1.MemWriteM = 0; b1.Funct3M = 0; b1.DataAdrM = 0; b1.WriteDataM = 0;
        cyc(0, 1, 0, 0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 32'd0);
        cyc(0, 1, 0, 0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 32'd0);
        idle(0, 2);
        @(negedge clk); #1;
        chk("reset_stall", 32'(b0.StallMem), 32'd0);
        chk("reset_cnt", 32'(b0.StallCount), 32'd0);
        chk("reset_rdata", b0.ReadDataM, 32'd0);

        // LATENCY=2: store then load of the same word
        txn(0, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
        txn(0, 1, 0, 3'd2, 32'h10, 32'h0);
        chk("lw_deadbeef", last_rd[0], 32'hDEADBEEF);
        chk("stallcount6", 32'(b0.StallCount), 32'd6);

        for (int i = 0; i < 64; i++) txn(0, 0, 1, 3'd2, 32'(i * 4), $urandom);

        txn(0, 0, 1, 3'd2, 32'h20, 32'h80FF7F01);
        txn(0, 1, 0, 3'd0, 32'h23, 32'h0); chk("lb_23", last_rd[0], 32'hFFFFFF80);
        txn(0, 1, 0, 3'd4, 32'h23, 32'h0); chk("lbu_23", last_rd[0], 32'h00000080);
        txn(0, 1, 0, 3'd1, 32'h20, 32'h0); chk("lh_20", last_rd[0], 32'h00007F01);
        txn(0, 1, 0, 3'd5, 32'h22, 32'h0); chk("lhu_22", last_rd[0], 32'h000080FF);
        txn(0, 0, 1, 3'd0, 32'h21, 32'h123456AA);
        txn(0, 1, 0, 3'd2, 32'h20, 32'h0); chk("sb_merge", last_rd[0], 32'h80FFAA01);

        txn(0, 1, 0, 3'd2, 32'h12, 32'h0);
        chk("mis_lw12", 32'(last_mis[0]), 32'd1); chk("mis_lw12_st", 32'(last_st[0]), 32'd0);
        txn(0, 0, 1, 3'd1, 32'h11, 32'hFFFF_FFFF);
        chk("mis_sh11", 32'(last_mis[0]), 32'd1);
        txn(0, 1, 0, 3'd3, 32'h10, 32'h0);
        chk("mis_f3_011", 32'(last_mis[0]), 32'd1);
        txn(0, 0, 1, 3'd6, 32'h10, 32'h0);
        txn(0, 1, 0, 3'd2, 32'h10, 32'h0);
        txn(0, 1, 1, 3'd2, 32'h14, 32'h0BADF00D);

        // Reset lands in the second stall cycle of a store
        cyc(0, 0, 0, 1, 3'd2, 32'h30, 32'h12345678, 1, 1, 0, 32'd0);
        cyc(0, 1, 0, 1, 3'd2, 32'h30, 32'h12345678, 0, 0, 0, 32'd0);
        sc[0] = 32'd0; sc[1] = 32'd0;
        idle(0, 1);
        @(negedge clk); #1;
        chk("rst_mid_stall", 32'(b0.StallMem), 32'd0);
        chk("rst_mid_cnt", 32'(b0.StallCount), 32'd0);
        txn(0, 1, 0, 3'd2, 32'h30, 32'h0);

        txn(0, 0, 1, 3'd2, 32'h100, 32'hCAFEF00D);
        txn(0, 1, 0, 3'd2, 32'h000, 32'h0);
        chk("wrap_0x100", last_rd[0], 32'hCAFEF00D);

        for (int i = 0; i < 250; i++) begin
            rand_txn(0);
            if ($urandom_range(0, 3) == 0) idle(0, $urandom_range(1, 2));
        end
        chk("cnt_saturated", 32'(b0.StallCount), 32'd255);

        // LATENCY=0 build
        for (int i = 0; i < 64; i++) txn(1, 0, 1, 3'd2, 32'(i * 4), $urandom);
        txn(1, 0, 1, 3'd2, 32'h44, 32'h5A5A0001);
        txn(1, 1, 0, 3'd2, 32'h44, 32'h0);
        chk("l0_b2b_load", last_rd[1], 32'h5A5A0001);
        chk("l0_no_stall", 32'(last_st[1]), 32'd0);
        for (int i = 0; i < 200; i++) begin
            rand_txn(1);
            if ($urandom_range(0, 3) == 0) idle(1, 1);
        end
        chk("l0_cnt_zero", b1.StallCount, 32'd0);

        idle(0, 2);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
